// File: rtl/rv_iopmp_err_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : rv_iopmp_err_arbiter_if
// Brief    : Error-record request bus and capture-side bus of the arbiter.
// Revision : 1.0
// ============================================================================
interface rv_iopmp_err_arbiter_if #(
    parameter int NUMBER_IOPMP_INSTANCES = 2,
    parameter int FIFO_DEPTH             = 4,
    parameter int RRID_WIDTH             = 8,
    parameter int EID_WIDTH              = 8,
    parameter int ADDR_WIDTH             = 64
);
    localparam int REC_W   = 5 + RRID_WIDTH + EID_WIDTH + ADDR_WIDTH;
    localparam int C_SRC_W = (NUMBER_IOPMP_INSTANCES > 1) ? $clog2(NUMBER_IOPMP_INSTANCES) : 1;
    localparam int C_CNT_W = $clog2(FIFO_DEPTH) + 1;

    logic [NUMBER_IOPMP_INSTANCES-1:0]       err_valid_i;
    logic [NUMBER_IOPMP_INSTANCES-1:0]       err_ready_o;
    logic [NUMBER_IOPMP_INSTANCES*REC_W-1:0] err_rec_i;
    logic                                    cap_valid_o;
    logic                                    cap_ready_i;
    logic [REC_W-1:0]                        cap_rec_o;
    logic [C_SRC_W-1:0]                      cap_src_o;
    logic [C_CNT_W-1:0]                      count_o;

    // Signal names are given from the arbiter's point of view.
    modport slave (
        input  err_valid_i, err_rec_i, cap_ready_i,
        output err_ready_o, cap_valid_o, cap_rec_o, cap_src_o, count_o
    );

    modport master (
        output err_valid_i, err_rec_i, cap_ready_i,
        input  err_ready_o, cap_valid_o, cap_rec_o, cap_src_o, count_o
    );
endinterface
`default_nettype wire

// File: rtl/rv_iopmp_err_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : rv_iopmp_err_arbiter
// Brief    : Round-robin collection of IOPMP error records into a FIFO.
// Revision : 1.0
// ============================================================================
module rv_iopmp_err_arbiter #(
    parameter int NUMBER_IOPMP_INSTANCES = 2,
    parameter int FIFO_DEPTH             = 4,
    parameter int RRID_WIDTH             = 8,
    parameter int EID_WIDTH              = 8,
    parameter int ADDR_WIDTH             = 64
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  flush_i,
    rv_iopmp_err_arbiter_if.slave bus
);
    localparam int N       = NUMBER_IOPMP_INSTANCES;
    localparam int REC_W   = 5 + RRID_WIDTH + EID_WIDTH + ADDR_WIDTH;
    localparam int C_SRC_W = (N > 1) ? $clog2(N) : 1;
    localparam int C_PTR_W = $clog2(FIFO_DEPTH);
    localparam int C_CNT_W = C_PTR_W + 1;

    logic [REC_W-1:0]   rec_mem_q [FIFO_DEPTH];
    logic [C_SRC_W-1:0] src_mem_q [FIFO_DEPTH];
    logic [C_PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [C_CNT_W-1:0] count_q, count_d;
    logic [C_SRC_W-1:0] rr_ptr_q, rr_ptr_d;

    logic               w_full, w_empty, w_any, w_push, w_pop;
    logic [C_SRC_W-1:0] w_gnt_idx;
    logic [C_SRC_W:0]   w_cand;
    logic [REC_W-1:0]   w_gnt_rec;

    assign w_full  = (count_q == C_CNT_W'(FIFO_DEPTH));
    assign w_empty = (count_q == '0);

    // Walk candidates rr_ptr, rr_ptr+1, ... modulo N; the first requester wins.
    always_comb begin : arb
        w_any     = 1'b0;
        w_gnt_idx = '0;
        w_cand    = '0;
        for (int i = 0; i < N; i++) begin
            w_cand = {1'b0, rr_ptr_q} + (C_SRC_W+1)'(i);
            if (w_cand >= (C_SRC_W+1)'(N)) begin
                w_cand = w_cand - (C_SRC_W+1)'(N);
            end
            if (!w_any && bus.err_valid_i[w_cand[C_SRC_W-1:0]]) begin
                w_any     = 1'b1;
                w_gnt_idx = w_cand[C_SRC_W-1:0];
            end
        end
    end

    always_comb begin : rec_mux
        w_gnt_rec = '0;
        for (int g = 0; g < N; g++) begin
            if (C_SRC_W'(g) == w_gnt_idx) begin
                w_gnt_rec = bus.err_rec_i[g*REC_W +: REC_W];
            end
        end
    end

    // Acceptance never looks at cap_ready_i: a full FIFO stalls even if popped.
    assign w_push = w_any & ~w_full & ~flush_i & ~rst_i;
    assign w_pop  = ~w_empty & bus.cap_ready_i & ~flush_i;

    generate
        for (genvar g = 0; g < N; g++) begin : g_ready
            assign bus.err_ready_o[g] = w_push & (w_gnt_idx == C_SRC_W'(g));
        end
    endgenerate

    always_comb begin : next_state
        rr_ptr_d = rr_ptr_q;
        if (w_push) begin
            rr_ptr_d = (w_gnt_idx == C_SRC_W'(N - 1)) ? '0 : w_gnt_idx + C_SRC_W'(1);
        end
        count_d = count_q;
        if (flush_i) begin
            count_d = '0;
        end else if (w_push && !w_pop) begin
            count_d = count_q + C_CNT_W'(1);
        end else if (!w_push && w_pop) begin
            count_d = count_q - C_CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            rr_ptr_q <= '0;
            for (int k = 0; k < FIFO_DEPTH; k++) begin
                rec_mem_q[k] <= '0;
                src_mem_q[k] <= '0;
            end
        end else begin
            count_q  <= count_d;
            rr_ptr_q <= rr_ptr_d;
            if (flush_i) begin
                wr_ptr_q <= '0;
                rd_ptr_q <= '0;
            end else begin
                if (w_push) begin
                    rec_mem_q[wr_ptr_q] <= w_gnt_rec;
                    src_mem_q[wr_ptr_q] <= w_gnt_idx;
                    wr_ptr_q            <= wr_ptr_q + C_PTR_W'(1);
                end
                if (w_pop) begin
                    rd_ptr_q <= rd_ptr_q + C_PTR_W'(1);
                end
            end
        end
    end

    assign bus.cap_valid_o = ~w_empty;
    assign bus.cap_rec_o   = rec_mem_q[rd_ptr_q];
    assign bus.cap_src_o   = src_mem_q[rd_ptr_q];
    assign bus.count_o     = count_q;
endmodule
`default_nettype wire

// File: tb/tb_rv_iopmp_err_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_rv_iopmp_err_arbiter
// Brief    : Randomized requesters and capture side against a queue model.
// Revision : 1.0
// ============================================================================
module tb_rv_iopmp_err_arbiter;
    localparam int N       = 2;
    localparam int DEPTH   = 4;
    localparam int REC_W   = 5 + 8 + 8 + 64;

    typedef struct {
        logic [REC_W-1:0] rec;
        int               src;
    } ent_t;

    logic clk_i;
    logic rst_i;
    logic flush_i;

    rv_iopmp_err_arbiter_if #(
        .NUMBER_IOPMP_INSTANCES(N),
        .FIFO_DEPTH(DEPTH)
    ) bus ();

    rv_iopmp_err_arbiter #(
        .NUMBER_IOPMP_INSTANCES(N),
        .FIFO_DEPTH(DEPTH)
    ) u_dut (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .flush_i (flush_i),
        .bus     (bus.slave)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    int               n_total;
    int               n_bad;
    ent_t             q[$];
    int               rr;
    bit               zero_known;
    bit               vld [N];
    logic [REC_W-1:0] rec [N];

    task automatic check_val(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_total++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [REC_W-1:0] rand_rec();
        logic [1:0]  ttype;
        logic [2:0]  etype;
        logic [7:0]  rrid;
        logic [7:0]  eid;
        logic [63:0] addr;
        ttype = 2'($urandom_range(1, 2));
        etype = 3'($urandom_range(0, 7));
        rrid  = 8'($urandom);
        eid   = 8'($urandom);
        addr  = {32'($urandom), 32'($urandom)};
        return {ttype, etype, rrid, eid, addr};
    endfunction

    // One clock cycle, entered and left at the falling edge.
    task automatic run_cycle(input int p_new, input int p_rdy, input int p_flush, input bit do_rst);
        logic [N-1:0] exp_rdy;
        int           g;
        bit           found;

        check_val("cap_valid", 128'(bus.cap_valid_o), 128'(q.size() != 0));
        check_val("count", 128'(bus.count_o), 128'(q.size()));
        if (q.size() != 0) begin
            check_val("cap_rec", 128'(bus.cap_rec_o), 128'(q[0].rec));
            check_val("cap_src", 128'(bus.cap_src_o), 128'(q[0].src));
        end else if (zero_known) begin
            check_val("cap_rec_rst", 128'(bus.cap_rec_o), 128'(0));
            check_val("cap_src_rst", 128'(bus.cap_src_o), 128'(0));
        end

        for (int i = 0; i < N; i++) begin
            if (!vld[i] && $urandom_range(0, 99) < p_new) begin
                vld[i] = 1'b1;
                rec[i] = rand_rec();
            end
            bus.err_valid_i[i]                 = vld[i];
            bus.err_rec_i[i*REC_W +: REC_W]    = rec[i];
        end
        bus.cap_ready_i = ($urandom_range(0, 99) < p_rdy);
        flush_i         = ($urandom_range(0, 99) < p_flush);
        rst_i           = do_rst;
        #1;

        exp_rdy = '0;
        g       = -1;
        found   = 1'b0;
        if (!rst_i && !flush_i && q.size() < DEPTH) begin
            for (int k = 0; k < N; k++) begin
                int c;
                c = (rr + k) % N;
                if (!found && vld[c]) begin
                    found = 1'b1;
                    g     = c;
                end
            end
        end
        if (found) exp_rdy[g] = 1'b1;
        check_val("err_ready", 128'(bus.err_ready_o), 128'(exp_rdy));

        if (rst_i) begin
            q.delete();
            rr         = 0;
            zero_known = 1'b1;
        end else if (flush_i) begin
            q.delete();
        end else begin
            if (q.size() != 0 && bus.cap_ready_i) void'(q.pop_front());
            if (found) begin
                q.push_back('{rec: rec[g], src: g});
                rr         = (g + 1) % N;
                vld[g]     = 1'b0;
                zero_known = 1'b0;
            end
        end

        @(posedge clk_i);
        @(negedge clk_i);
    endtask

    initial begin
        n_total         = 0;
        n_bad           = 0;
        rr              = 0;
        zero_known      = 1'b1;
        rst_i           = 1'b1;
        flush_i         = 1'b0;
        bus.err_valid_i = '0;
        bus.err_rec_i   = '0;
        bus.cap_ready_i = 1'b0;
        for (int i = 0; i < N; i++) begin
            vld[i] = 1'b0;
            rec[i] = '0;
        end
        repeat (2) @(posedge clk_i);
        @(negedge clk_i);

        run_cycle(0, 0, 0, 1'b1);
        repeat (200) run_cycle(30, 50, 0, 1'b0);
        repeat (200) run_cycle(90, 10, 0, 1'b0);
        // Full FIFO with both requesters still pending, then reset mid-stream.
        repeat (10) run_cycle(100, 0, 0, 1'b0);
        repeat (2) run_cycle(100, 50, 0, 1'b1);
        repeat (300) run_cycle(60, 60, 4, 1'b0);
        repeat (150) run_cycle(80, 30, 2, 1'b0);
        repeat (100) run_cycle(0, 80, 0, 1'b0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule
`default_nettype wire
